adc_frame_packer: RTL and testbench

// Consumer of the readout sequencer's delayed ADC data-valid strobe. Captures one ADC channel's samples,

---
 rtl/adc_frame_packer.sv | 141 ++++++++++++++
 tb/tb_adc_frame_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - packs one ADC channel's samples two per 32-bit word, framed by header/trailer words.
// The ADC cannot stall, so a write that meets fifo_full is dropped and flagged rather than held back.
module adc_frame_packer #(
  parameter int ADC_W = 14,
  parameter int FRM_W = 16
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             frame_arm,
  input  logic             adc_dat_valid,
  input  logic [ADC_W-1:0] adc_dat,
  input  logic [15:0]      samp_per_row,
  input  logic [9:0]       num_row,
  input  logic             fifo_full,
  input  logic             clr_err,
  output logic             fifo_wr_en,
  output logic [31:0]      fifo_din,
  output logic             busy,
  output logic             frame_done,
  output logic [2:0]       err
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_TRL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [FRM_W-1:0] r_frame_cnt;
  logic [15:0]      r_samp_cnt;
  logic [9:0]       r_row_cnt;
  logic             r_half_sel;
  logic [15:0]      r_held;

  logic [15:0] w_samp;
  logic [15:0] w_frm16;
  logic [15:0] w_spr_m1;
  logic [9:0]  w_nr_m1;
  logic        w_last_samp;
  logic        w_last_row;
  logic        w_take;
  logic        w_wr_due;
  logic [31:0] w_wr_data;
  logic        w_done_due;
  logic [2:0]  w_err_set;

  assign w_samp      = 16'(adc_dat);
  assign w_frm16     = 16'(r_frame_cnt);
  // A programmed count of zero behaves like one.
  assign w_spr_m1    = (samp_per_row == 16'd0) ? 16'd0 : samp_per_row - 16'd1;
  assign w_nr_m1     = (num_row == 10'd0) ? 10'd0 : num_row - 10'd1;
  assign w_last_samp = (r_samp_cnt == w_spr_m1);
  assign w_last_row  = (r_row_cnt == w_nr_m1);
  assign w_take      = (r_state == S_DATA) && adc_dat_valid;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_due    = 1'b0;
    w_wr_data   = 32'h0;
    w_done_due  = 1'b0;
    case (r_state)
      S_IDLE: if (frame_arm) w_state_nxt = S_HDR;
      S_HDR: begin
        w_wr_due    = 1'b1;
        w_wr_data   = {16'hF00D, w_frm16};
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (adc_dat_valid) begin
          if (w_last_samp) begin
            w_wr_due  = 1'b1;
            w_wr_data = r_half_sel ? {w_samp, r_held} : {16'h0000, w_samp};
            if (w_last_row) w_state_nxt = S_TRL;
          end else if (r_half_sel) begin
            w_wr_due  = 1'b1;
            w_wr_data = {w_samp, r_held};
          end
        end
      end
      S_TRL: begin
        w_wr_due    = 1'b1;
        w_wr_data   = {16'hE0F0, w_frm16};
        w_done_due  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_err_set = {adc_dat_valid && (r_state != S_DATA),
                      frame_arm && (r_state != S_IDLE),
                      w_wr_due && fifo_full};

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_samp_cnt  <= 16'd0;
      r_row_cnt   <= 10'd0;
      r_half_sel  <= 1'b0;
      r_held      <= 16'd0;
    end else begin
      if ((r_state == S_IDLE) && frame_arm) begin
        r_samp_cnt <= 16'd0;
        r_row_cnt  <= 10'd0;
        r_half_sel <= 1'b0;
      end
      if (w_take) begin
        if (w_last_samp) begin
          r_samp_cnt <= 16'd0;
          r_half_sel <= 1'b0;
          r_row_cnt  <= r_row_cnt + 10'd1;
        end else begin
          r_samp_cnt <= r_samp_cnt + 16'd1;
          r_half_sel <= ~r_half_sel;
          if (!r_half_sel) r_held <= w_samp;
        end
      end
      if (r_state == S_TRL) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // Dropped words still count as written: only the strobe is suppressed.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= 32'h0;
      frame_done <= 1'b0;
      err        <= 3'b000;
    end else begin
      fifo_wr_en <= w_wr_due && !fifo_full;
      if (w_wr_due && !fifo_full) fifo_din <= w_wr_data;
      frame_done <= w_done_due;
      err        <= (clr_err ? 3'b000 : err) | w_err_set;
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb/tb_adc_frame_packer.sv - scoreboard bench for adc_frame_packer (FRM_W=2 so the frame counter wraps quickly).
module tb_adc_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_arm;
  logic        adc_dat_valid;
  logic [13:0] adc_dat;
  logic [15:0] samp_per_row;
  logic [9:0]  num_row;
  logic        fifo_full;
  logic        clr_err;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        busy;
  logic        frame_done;
  logic [2:0]  err;

  logic [32:0] obs_q[$];
  logic [32:0] exp_q[$];
  int          samp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_stray  = 0;

  always #5 clk = ~clk;

  adc_frame_packer #(.ADC_W(14), .FRM_W(2)) dut (
    .CLK(clk), .rst_n(rst_n), .frame_arm(frame_arm), .adc_dat_valid(adc_dat_valid),
    .adc_dat(adc_dat), .samp_per_row(samp_per_row), .num_row(num_row),
    .fifo_full(fifo_full), .clr_err(clr_err), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .busy(busy), .frame_done(frame_done), .err(err)
  );

  // Each written word is recorded with frame_done as bit 32.
  always @(negedge clk) begin
    if (fifo_wr_en) obs_q.push_back({frame_done, fifo_din});
    else if (frame_done) n_stray++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; frame_arm = 1'b0; adc_dat_valid = 1'b0; adc_dat = 14'd0;
    fifo_full = 1'b0; clr_err = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic send_frame(input int spr, input int nr, input int full_at, input int arm_at);
    samp_per_row = 16'(spr);
    num_row      = 10'(nr);
    frame_arm    = 1'b1;
    tick;
    frame_arm    = 1'b0;
    tick;
    for (int i = 0; i < samp_q.size(); i++) begin
      adc_dat       = 14'(samp_q[i]);
      adc_dat_valid = 1'b1;
      fifo_full     = (i == full_at);
      frame_arm     = (i == arm_at);
      tick;
    end
    adc_dat_valid = 1'b0; fifo_full = 1'b0; frame_arm = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; frame_arm = 1'b0; adc_dat_valid = 1'b0; adc_dat = 14'd0;
    samp_per_row = 16'd0; num_row = 10'd0; fifo_full = 1'b0; clr_err = 1'b0;
    tick; tick;
    n_checks++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
    n_checks++; if (fifo_din !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h expected 00000000", fifo_din); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    n_checks++; if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b expected 000", err); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    logic [32:0] e, o;
    do_reset;
    samp_q = {1, 2, 3, 4, 5, 6, 7, 8};
    exp_q.push_back({1'b0, 32'hF00D0000}); exp_q.push_back({1'b0, 32'h00020001});
    exp_q.push_back({1'b0, 32'h00040003}); exp_q.push_back({1'b0, 32'h00060005});
    exp_q.push_back({1'b0, 32'h00080007}); exp_q.push_back({1'b1, 32'hE0F00000});
    send_frame(4, 2, -1, -1);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t1_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL t1_word: got %h expected %h", o, e); end
    end
    n_checks++; if (err !== 3'b000) begin n_fail++; $display("FAIL t1_err: got %b expected 000", err); end
  endtask

  task automatic test_odd_row;
    logic [32:0] e, o;
    do_reset;
    samp_q = {'h3FFF, 'h0001, 'h0002};
    exp_q.push_back({1'b0, 32'hF00D0000}); exp_q.push_back({1'b0, 32'h00013FFF});
    exp_q.push_back({1'b0, 32'h00000002}); exp_q.push_back({1'b1, 32'hE0F00000});
    send_frame(3, 1, -1, -1);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t2_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL t2_word: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_fifo_full;
    logic [32:0] e, o;
    do_reset;
    samp_q = {1, 2, 3, 4, 5, 6, 7, 8};
    exp_q.push_back({1'b0, 32'hF00D0000}); exp_q.push_back({1'b0, 32'h00020001});
    exp_q.push_back({1'b0, 32'h00060005}); exp_q.push_back({1'b0, 32'h00080007});
    exp_q.push_back({1'b1, 32'hE0F00000});
    send_frame(4, 2, 3, -1);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t3_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL t3_word: got %h expected %h", o, e); end
    end
    n_checks++; if (err !== 3'b001) begin n_fail++; $display("FAIL t3_err: got %b expected 001", err); end
  endtask

  task automatic test_err_flags;
    logic [32:0] e, o;
    do_reset;
    adc_dat = 14'h3AB; adc_dat_valid = 1'b1;
    tick;
    adc_dat_valid = 1'b0;
    tick;
    samp_q = {1, 2, 3, 4, 5, 6, 7, 8};
    exp_q.push_back({1'b0, 32'hF00D0000}); exp_q.push_back({1'b0, 32'h00020001});
    exp_q.push_back({1'b0, 32'h00040003}); exp_q.push_back({1'b0, 32'h00060005});
    exp_q.push_back({1'b0, 32'h00080007}); exp_q.push_back({1'b1, 32'hE0F00000});
    send_frame(4, 2, -1, 2);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t4_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL t4_word: got %h expected %h", o, e); end
    end
    n_checks++; if (err !== 3'b110) begin n_fail++; $display("FAIL t4_err: got %b expected 110", err); end
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    tick;
    n_checks++; if (err !== 3'b000) begin n_fail++; $display("FAIL t4_clr_err: got %b expected 000", err); end
  endtask

  task automatic test_frame_wrap;
    logic [32:0] e, o;
    do_reset;
    for (int k = 0; k < 7; k++) begin
      samp_q = {2 * k + 1, 2 * k + 2};
      exp_q.push_back({1'b0, 16'hF00D, 16'(k % 4)});
      exp_q.push_back({1'b0, 16'(2 * k + 2), 16'(2 * k + 1)});
      exp_q.push_back({1'b1, 16'hE0F0, 16'(k % 4)});
      send_frame(2, 1, -1, -1);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t5_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL t5_word: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [32:0] e, o;
    do_reset;
    samp_per_row = 16'd4; num_row = 10'd2;
    frame_arm = 1'b1; tick; frame_arm = 1'b0; tick;
    for (int i = 0; i < 3; i++) begin
      adc_dat = 14'(i + 1); adc_dat_valid = 1'b1; tick;
    end
    adc_dat_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t6_busy_before: got %b expected 1", busy); end
    #2;
    obs_q.delete();
    rst_n = 1'b0;
    #1;
    n_checks++; if ({fifo_wr_en, frame_done, busy} !== 3'b000) begin n_fail++; $display("FAIL t6_async_ctrl: got %b expected 000", {fifo_wr_en, frame_done, busy}); end
    n_checks++; if (fifo_din !== 32'h0) begin n_fail++; $display("FAIL t6_async_din: got %h expected 00000000", fifo_din); end
    n_checks++; if (err !== 3'b000) begin n_fail++; $display("FAIL t6_async_err: got %b expected 000", err); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    obs_q.delete();
    samp_q = {'h3FFF, 'h0001, 'h0002};
    exp_q.push_back({1'b0, 32'hF00D0000}); exp_q.push_back({1'b0, 32'h00013FFF});
    exp_q.push_back({1'b0, 32'h00000002}); exp_q.push_back({1'b1, 32'hE0F00000});
    send_frame(3, 1, -1, -1);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL t6_count: got %0d words expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL t6_word: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_no_stray_done;
    n_checks++;
    if (n_stray != 0) begin n_fail++; $display("FAIL stray_frame_done: got %0d pulses without a write expected 0", n_stray); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_odd_row;
    test_fifo_full;
    test_err_flags;
    test_frame_wrap;
    test_reset_mid_frame;
    test_no_stray_done;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
